// File: rtl/logreg_pkg.sv
// Shared constants, FSM state type and bias helper for the streaming
// logistic-regression multiply-accumulate.
package logreg_pkg;

   localparam int DEF_N_FEAT     = 80;
   localparam int DEF_X_W        = 7;
   localparam int DEF_TH_W       = 32;
   localparam int DEF_ACC_W      = 32;
   localparam int DEF_BIAS_SHIFT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Worked at 64 bits so any TH_W/ACC_W up to 64 can truncate from one result.
   function automatic logic signed [63:0] bias_term(input logic signed [63:0] theta0,
                                                    input int shift);
      return theta0 <<< shift;
   endfunction

endpackage

// File: rtl/logreg_coef_rf.sv
// Runtime-writable coefficient store: THETA0 (bias) plus one coefficient per
// feature, one write port, one combinational read port and a direct bias tap.
module logreg_coef_rf #(
   parameter int N_FEAT = 80,
   parameter int TH_W   = 32,
   parameter int ADDR_W = $clog2(N_FEAT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [TH_W-1:0]   wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [TH_W-1:0]   rdata,
   output logic [TH_W-1:0]   theta0
);

   logic [TH_W-1:0] mem_q [N_FEAT+1];
   logic [TH_W-1:0] mem_d [N_FEAT+1];

   // Addresses beyond the last feature are dropped rather than aliased.
   always_comb begin
      mem_d = mem_q;
      if (we && (waddr <= ADDR_W'(N_FEAT))) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata  = mem_q[raddr];
   assign theta0 = mem_q[0];

endmodule

// File: rtl/logreg_stream_mac.sv
// Time-multiplexed logistic-regression inner product: one feature per beat,
// a single MAC, and a held result presented over a valid/ready handshake.
module logreg_stream_mac
   import logreg_pkg::*;
#(
   parameter int N_FEAT     = DEF_N_FEAT,
   parameter int X_W        = DEF_X_W,
   parameter int TH_W       = DEF_TH_W,
   parameter int ACC_W      = DEF_ACC_W,
   parameter int BIAS_SHIFT = DEF_BIAS_SHIFT
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [X_W-1:0]                 in_data,
   input  logic                           in_last,
   input  logic                           cfg_we,
   input  logic [$clog2(N_FEAT+1)-1:0]    cfg_addr,
   input  logic [TH_W-1:0]                cfg_data,
   output logic                           cfg_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_data,
   output logic                           out_err
);

   localparam int CNT_W  = $clog2(N_FEAT + 1);
   localparam int PROD_W = X_W + 1 + TH_W;

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [ACC_W-1:0]           acc_q, acc_d;
   logic [ACC_W-1:0]           out_data_q, out_data_d;
   logic                       out_err_q, out_err_d;

   logic [TH_W-1:0]            theta_rd;
   logic [TH_W-1:0]            theta0;
   logic signed [PROD_W-1:0]   x_ext, th_ext, prod;
   logic signed [63:0]         bias_full;
   logic [ACC_W-1:0]           term, bias, acc_base, acc_next;
   logic                       beat, at_last_idx, frame_end;

   logreg_coef_rf #(
      .N_FEAT (N_FEAT),
      .TH_W   (TH_W),
      .ADDR_W (CNT_W)
   ) u_coef_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (cfg_we && cfg_ready),
      .waddr  (cfg_addr),
      .wdata  (cfg_data),
      .raddr  (cnt_q),
      .rdata  (theta_rd),
      .theta0 (theta0)
   );

   assign in_ready  = (state_q != ST_DONE);
   assign cfg_ready = (state_q == ST_IDLE) && !in_valid;
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

   // Feature is zero-extended so the product is signed only through THETA.
   always_comb begin
      x_ext       = PROD_W'($signed({1'b0, in_data}));
      th_ext      = PROD_W'($signed(theta_rd));
      prod        = x_ext * th_ext;
      term        = ACC_W'(prod);
      bias_full   = bias_term(64'($signed(theta0)), BIAS_SHIFT);
      bias        = ACC_W'(bias_full);
      acc_base    = (state_q == ST_IDLE) ? bias : acc_q;
      acc_next    = acc_base + term;
      beat        = in_valid && in_ready;
      at_last_idx = (cnt_q == CNT_W'(N_FEAT));
      frame_end   = in_last || at_last_idx;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (beat) begin
               acc_d = acc_next;
               if (frame_end) begin
                  cnt_d      = CNT_W'(1);
                  out_data_d = acc_next;
                  out_err_d  = in_last ^ at_last_idx;
                  state_d    = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_W'(1);
         acc_q      <= '0;
         out_data_q <= '0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_err_q  <= out_err_d;
      end
   end

endmodule

// File: tb/tb_logreg_stream_mac.sv
// Directed bench for logreg_stream_mac with N_FEAT=4; expected results are
// queued at stimulus time and popped by an independent output monitor.
module tb_logreg_stream_mac;

   localparam int N_FEAT     = 4;
   localparam int X_W        = 7;
   localparam int TH_W       = 32;
   localparam int ACC_W      = 32;
   localparam int BIAS_SHIFT = 16;
   localparam int AW         = $clog2(N_FEAT + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [X_W-1:0]   in_data;
   logic             in_last;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [TH_W-1:0]  cfg_data;
   logic             cfg_ready;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             out_err;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   exp_t expItem;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logreg_stream_mac #(
      .N_FEAT     (N_FEAT),
      .X_W        (X_W),
      .TH_W       (TH_W),
      .ACC_W      (ACC_W),
      .BIAS_SHIFT (BIAS_SHIFT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeCoef(input logic [AW-1:0] addr, input logic [TH_W-1:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [X_W-1:0] x, input logic last);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
      end
      tick();
   endtask

   task automatic sendFrame(input logic [X_W-1:0] x1, input logic [X_W-1:0] x2,
                            input logic [X_W-1:0] x3, input logic [X_W-1:0] x4,
                            input int nBeats, input int lastBeat);
      logic [X_W-1:0] xs [4];
      xs[0] = x1;
      xs[1] = x2;
      xs[2] = x3;
      xs[3] = x4;
      for (int i = 0; i < nBeats; i++) begin
         applyStimulus(xs[i], (i + 1) == lastBeat);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic checkLatency(input string name);
      @(negedge clk);
      checkOutput(name, out_valid, 1);
      tick();
   endtask

   task automatic pushExp(input logic [31:0] data, input logic err);
      exp_t e;
      e.data = data;
      e.err  = err;
      expQ.push_back(e);
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, expected no result", out_data);
         end else begin
            expItem = expQ.pop_front();
            checkOutput("out_data", out_data, expItem.data);
            checkOutput("out_err", out_err, expItem.err);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected simulation to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      out_ready = 1'b1;
      repeat (3) tick();

      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_out_err", out_err, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_cfg_ready", cfg_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();

      writeCoef(0, 32'd1);
      writeCoef(1, 32'd2);
      writeCoef(2, 32'hFFFF_FFFD);
      writeCoef(3, 32'd4);
      writeCoef(4, 32'd5);

      $display("[TB] nominal frame");
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_nominal");

      $display("[TB] early in_last");
      pushExp(32'd65532, 1'b1);
      sendFrame(1, 2, 0, 0, 2, 2);
      checkLatency("latency_early");
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_after_early");

      $display("[TB] missing in_last");
      pushExp(32'd65564, 1'b1);
      sendFrame(1, 2, 3, 4, 4, 0);
      checkLatency("latency_missing");
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_after_missing");

      $display("[TB] output backpressure");
      out_ready = 1'b0;
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      in_valid = 1'b1;
      in_data  = 7'd1;
      in_last  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_out_data", out_data, 32'd65564);
         checkOutput("stall_in_ready", in_ready, 0);
         checkOutput("stall_out_valid", out_valid, 1);
      end
      tick();
      out_ready = 1'b1;
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_after_stall");

      $display("[TB] dropped coefficient writes");
      pushExp(32'd65564, 1'b0);
      applyStimulus(1, 1'b0);
      cfg_we   = 1'b1;
      cfg_addr = 1;
      cfg_data = 32'd100;
      #1;
      checkOutput("cfg_ready_accum", cfg_ready, 0);
      applyStimulus(2, 1'b0);
      cfg_we = 1'b0;
      applyStimulus(3, 1'b0);
      applyStimulus(4, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkLatency("latency_cfg_accum");

      pushExp(32'd65564, 1'b0);
      in_valid = 1'b1;
      in_data  = 7'd1;
      in_last  = 1'b0;
      cfg_we   = 1'b1;
      cfg_addr = 2;
      cfg_data = 32'd1000;
      #1;
      checkOutput("cfg_ready_in_valid", cfg_ready, 0);
      applyStimulus(1, 1'b0);
      cfg_we = 1'b0;
      sendFrame(2, 3, 4, 0, 3, 3);
      checkLatency("latency_cfg_valid");

      writeCoef(5, 32'd12345);
      pushExp(32'd65564, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_cfg_range");

      $display("[TB] reset mid-frame");
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b0);
      in_valid = 1'b1;
      in_data  = 7'd3;
      rst_n    = 1'b0;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_data", out_data, 0);
      checkOutput("midrst_out_err", out_err, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("midrst_no_output", out_valid, 0);
      end
      tick();
      pushExp(32'd0, 1'b0);
      sendFrame(1, 2, 3, 4, 4, 4);
      checkLatency("latency_after_reset");

      $display("[TB] accumulator wrap");
      writeCoef(0, 32'hFFFF_FFFF);
      writeCoef(1, 32'h7FFF_FFFF);
      pushExp(32'hFFFE_FFFE, 1'b0);
      sendFrame(2, 5, 6, 7, 4, 4);
      checkLatency("latency_wrap_bias");
      writeCoef(0, 32'd0);
      pushExp(32'hFFFF_FFFE, 1'b0);
      sendFrame(2, 0, 0, 0, 4, 4);
      checkLatency("latency_wrap");

      for (int i = 0; i < 50 && expQ.size() != 0; i++) begin
         tick();
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending results, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
